// File: rtl/imm_ext_pipe.sv
// Pipelined MIPS immediate extension stage with a 2-entry skid buffer and registered in_ready.
// Optional macro IMM_EXT_CNT_EN builds the accepted-output counter on out_count.
//
// state    | meaning
// ST_EMPTY | no item buffered
// ST_ONE   | main register holds the output item
// ST_FULL  | main and skid registers both hold items
module imm_ext_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic [31:0]      out_count
);

   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

   state_t             state_q, state_d;
   logic               in_ready_q, in_ready_d;
   logic [OUT_W-1:0]   main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
   logic [TAG_W-1:0]   main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
   logic [OUT_W-1:0]   zext_imm, sext_imm, ext_imm;
   logic               in_xfer, out_xfer;

   assign zext_imm = {{(OUT_W-IN_W){1'b0}}, in_imm};
   assign sext_imm = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

   // Shifts keep LUI/branch forms legal even when OUT_W == 2*IN_W.
   always_comb begin
      ext_imm = zext_imm;
      case (in_mode)
         2'b00:   ext_imm = zext_imm;
         2'b01:   ext_imm = sext_imm;
         2'b10:   ext_imm = zext_imm << IN_W;
         default: ext_imm = sext_imm << 2;
      endcase
   end

   assign out_valid = (state_q != ST_EMPTY);
   assign in_ready  = in_ready_q;
   assign out_imm   = main_imm_q;
   assign out_tag   = main_tag_q;
   assign in_xfer   = in_valid & in_ready_q;
   assign out_xfer  = out_valid & out_ready;

   always_comb begin
      state_d    = state_q;
      main_imm_d = main_imm_q;
      main_tag_d = main_tag_q;
      skid_imm_d = skid_imm_q;
      skid_tag_d = skid_tag_q;
      case (state_q)
         ST_EMPTY: begin
            if (in_xfer) begin
               main_imm_d = ext_imm;
               main_tag_d = in_tag;
               state_d    = ST_ONE;
            end
         end
         ST_ONE: begin
            if (in_xfer && !out_xfer) begin
               skid_imm_d = ext_imm;
               skid_tag_d = in_tag;
               state_d    = ST_FULL;
            end else if (in_xfer && out_xfer) begin
               main_imm_d = ext_imm;
               main_tag_d = in_tag;
            end else if (out_xfer) begin
               state_d    = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (out_xfer) begin
               main_imm_d = skid_imm_q;
               main_tag_d = skid_tag_q;
               state_d    = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      in_ready_d = (state_d != ST_FULL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b0;
         main_imm_q <= '0;
         main_tag_q <= '0;
         skid_imm_q <= '0;
         skid_tag_q <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         main_imm_q <= main_imm_d;
         main_tag_q <= main_tag_d;
         skid_imm_q <= skid_imm_d;
         skid_tag_q <= skid_tag_d;
      end
   end

`ifdef IMM_EXT_CNT_EN
   logic [31:0] cnt_q, cnt_d;

   assign cnt_d     = out_xfer ? cnt_q + 32'd1 : cnt_q;
   assign out_count = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   assign out_count = '0;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: a negedge monitor pushes modelled results on input
// transfers and pops/compares on output transfers; directed checks cover the corner cases.
module tb_imm_ext_pipe;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_imm = '0;
   logic [1:0]  in_mode = '0;
   logic [4:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_imm;
   logic [4:0]  out_tag;
   logic [31:0] out_count;

   int          total = 0;
   int          bad = 0;
   int          n_out = 0;
   logic [31:0] cnt_exp = '0;
   logic [36:0] sb_q[$];

   imm_ext_pipe dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_tag(out_tag),
      .out_count(out_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] mode);
      logic signed [31:0] s;
      s = 32'(signed'(imm));
      case (mode)
         2'd0:    return {16'h0000, imm};
         2'd1:    return s;
         2'd2:    return {imm, 16'h0000};
         default: return s * 4;
      endcase
   endfunction

   // Both transfers are evaluated as they will occur at the coming rising edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
         cnt_exp = '0;
      end else begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
            else begin
               logic [36:0] e;
               e = sb_q.pop_front();
               chk("sb_imm", 64'(out_imm), 64'(e[31:0]));
               chk("sb_tag", 64'(out_tag), 64'(e[36:32]));
            end
            n_out++;
            cnt_exp = cnt_exp + 32'd1;
         end
         if (in_valid && in_ready) sb_q.push_back({in_tag, model(in_imm, in_mode)});
      end
   end

   task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
      logic acc;
      int   n;
      in_valid = 1'b1; in_imm = imm; in_mode = mode; in_tag = tag;
      n = 0;
      do begin
         @(negedge clk); acc = in_ready;
         @(posedge clk); #1;
         n++;
      end while (!acc && n < 50);
      if (!acc) chk("send_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   logic [31:0] dir_exp[4];
   initial begin
      int base;
      dir_exp[0] = 32'h00008004; dir_exp[1] = 32'hFFFF8004;
      dir_exp[2] = 32'h80040000; dir_exp[3] = 32'hFFFE0010;

      #12;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_imm", 64'(out_imm), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_out_count", 64'(out_count), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick(1);
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      // One item per mode; result must be on out_* right after the accepting edge.
      out_ready = 1'b1;
      for (int m = 0; m < 4; m++) begin
         send(16'h8004, 2'(m), 5'(m + 4));
         chk("dir_valid", 64'(out_valid), 64'd1);
         chk("dir_imm", 64'(out_imm), 64'(dir_exp[m]));
         chk("dir_tag", 64'(out_tag), 64'(m + 4));
         tick(1);
      end
      send(16'h7FFF, 2'd1, 5'd9);
      chk("pos_sext", 64'(out_imm), 64'h00007FFF);
      send(16'h7FFF, 2'd3, 5'd10);
      chk("pos_branch", 64'(out_imm), 64'h0001FFFC);
      tick(1);
      chk("drained", 64'(out_valid), 64'd0);

      // Backpressure: two items fill the buffer, the third waits.
      out_ready = 1'b0;
      send(16'h0001, 2'd0, 5'd1);
      send(16'h0002, 2'd0, 5'd2);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b1; in_imm = 16'h0003; in_mode = 2'd0; in_tag = 5'd3;
      tick(3);
      chk("bp_hold_tag", 64'(out_tag), 64'd1);
      chk("bp_hold_imm", 64'(out_imm), 64'd1);
      chk("bp_still_full", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      send(16'h0003, 2'd0, 5'd3);
      tick(4);
      chk("bp_sb_empty", 64'(sb_q.size()), 64'd0);

      // Full-rate stream.
      base = n_out;
      for (int i = 0; i < 16; i++) begin
         send(16'($urandom), 2'($urandom_range(0, 3)), 5'(i));
         chk("stream_in_ready", 64'(in_ready), 64'd1);
      end
      chk("stream_rate", 64'(n_out - base), 64'd15);
      tick(1);
      chk("stream_outs", 64'(n_out - base), 64'd16);

      // Reset while FULL.
      out_ready = 1'b0;
      send(16'h1234, 2'd1, 5'd7);
      send(16'h5678, 2'd1, 5'd8);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 64'(out_valid), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd0);
      chk("midrst_imm", 64'(out_imm), 64'd0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      out_ready = 1'b1;
      send(16'hABCD, 2'd2, 5'd17);
      chk("after_rst_imm", 64'(out_imm), 64'hABCD0000);
      chk("after_rst_tag", 64'(out_tag), 64'd17);
      tick(2);
      chk("after_rst_empty", 64'(out_valid), 64'd0);

      // A few more transfers so the counter check covers a post-reset run.
      for (int i = 0; i < 5; i++) send(16'(i * 3), 2'd0, 5'(i));
      tick(2);
`ifdef IMM_EXT_CNT_EN
      chk("count", 64'(out_count), 64'(cnt_exp));
      chk("count_six", 64'(out_count), 64'd6);
`else
      chk("count_tied", 64'(out_count), 64'd0);
`endif
      chk("sb_final_empty", 64'(sb_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got=running expected=finished");
      $fatal(1);
   end
endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
Parametrised, pipelined immediate-extension stage for the MIPS datapath. It accepts a raw instruction immediate with an extension-mode code and a destination tag, and produces the OUT_W-bit operand. Four modes are supported: zero-extend, sign-extend, LUI upper placement, and branch offset (sign-extend, then shift left by 2). Valid/ready handshakes on both sides with a 2-entry skid buffer let it sit between decode and execute without combinational ready paths.

Parameters:
IN_W, 16, immediate input width
OUT_W, 32, extended output width; must satisfy OUT_W >= 2*IN_W and OUT_W >= IN_W+2
TAG_W, 5, sideband tag width (destination register index), passed through unchanged

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input item present
in_ready  output  1  stage can accept an item this cycle
in_imm  input  IN_W  raw immediate
in_mode  input  2  00 zero-ext, 01 sign-ext, 10 LUI, 11 branch offset
in_tag  input  TAG_W  sideband tag
out_valid  output  1  extended item present
out_ready  input  1  downstream accepts
out_imm  output  OUT_W  extended result
out_tag  output  TAG_W  tag of out_imm
out_count  output  32  accepted-output counter (IMM_EXT_CNT_EN only)

Behaviour:
- Reset, asynchronous on rst_n low: state EMPTY; out_valid=0, in_ready=0 while rst_n low and 1 from the first clk edge after release; out_imm=0, out_tag=0, out_count=0.
- Input transfer: in_valid & in_ready on a rising edge. Output transfer: out_valid & out_ready on a rising edge.
- Extension is computed combinationally from in_imm/in_mode before the first register:
  - 00: {OUT_W-IN_W zeros, imm}
  - 01: {OUT_W-IN_W copies of imm[IN_W-1], imm}
  - 10: {imm, IN_W zeros}, zero-filled above bit 2*IN_W-1
  - 11: sign-extend to OUT_W, then shift left 2; the top 2 bits are discarded
- Storage: main register (drives outputs) plus one skid register. States:
  - EMPTY: 0 entries
  - ONE: main valid
  - FULL: main and skid valid
- Transitions:
  - EMPTY + in xfer -> ONE
  - ONE + in xfer, no out xfer -> FULL (new item into skid)
  - ONE + out xfer, no in xfer -> EMPTY
  - ONE + both -> ONE (main reloaded with new item)
  - FULL + out xfer -> ONE (skid moves to main)
  - All other combinations: hold.
- in_ready is a registered signal: 1 in EMPTY/ONE, 0 in FULL. There is no combinational path from out_ready to in_ready.
- Latency: an item accepted at edge N appears on out_* after edge N, with out_valid=1 in cycle N+1 when the stage was empty. Throughput is 1 item/cycle while out_ready=1.
- out_imm/out_tag remain stable while out_valid=1 and out_ready=0. Items leave strictly in order; none is dropped or duplicated.
- in_valid while in_ready=0 is ignored; the upstream stage holds its item.
- Reset mid-operation discards all buffered items immediately.

Optional Feature:
IMM_EXT_CNT_EN:
- Defined: out_count increments by 1 on every output transfer, wraps 0xFFFFFFFF -> 0, and is cleared by reset.
- Undefined: out_count is tied to 0 and the counter logic is not built.

Test Plan:
- Reset, then one item per mode with imm=0x8004, out_ready=1 -> out_imm 0x00008004 / 0xFFFF8004 / 0x80040000 / 0xFFFE0010, one cycle after each acceptance; tags preserved.
- Positive values: imm=0x7FFF, mode 01 -> 0x00007FFF; mode 11 -> 0x0001FFFC.
- Backpressure: out_ready=0, stream 3 items (tags 1,2,3) -> items 1 and 2 accepted, in_ready=0 after the second; out_imm holds item 1. Raise out_ready -> tags emerge 1,2,3 in order, no loss.
- Full-rate streaming of 16 items with out_ready=1 and in_valid=1 -> one output per cycle, in_ready stays 1, ordering intact.
- Reset asserted while FULL -> out_valid=0 immediately, in_ready=0; after release the first new item emerges with correct value and no stale data.
- IMM_EXT_CNT_EN defined, 5 transfers -> out_count=5; preload the counter to 0xFFFFFFFF via a long run, or force it in simulation, then one transfer -> 0.
